// File: rtl/hdlc_rx_buffer_pkg.sv
// Shared FSM state type and default sizing for the HDLC receive frame buffer.
package hdlc_pkg;
    localparam int BUF_DEPTH = 128;
    localparam int FCS_BYTES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        READY = 2'd2
    } hdlc_state_t;
endpackage

// File: rtl/hdlc_rx_buffer_if.sv
// Signal bundle between the HDLC de-stuffer/host side and the receive frame buffer.
interface hdlc_rx_buffer_if;
    import hdlc_pkg::*;

    // Every strobe (Rx_NewByte, Rx_EoF, Rx_RdBuff, Rx_Drop) is one cycle wide and is
    // sampled on the rising clock edge; a read strobe returns data on Rx_DataBuff the
    // following cycle, and Rx_Ready is the only "valid" the host needs to watch.
    logic       Rx_NewByte;
    logic [7:0] Rx_Data;
    logic       Rx_ValidFrame;
    logic       Rx_EoF;
    logic       Rx_AbortSignal;
    logic       Rx_RdBuff;
    logic       Rx_Drop;
    logic       Rx_WrBuff;
    logic       Rx_Ready;
    logic [7:0] Rx_FrameSize;
    logic [7:0] Rx_DataBuff;
    logic       Rx_Overflow;
    logic       Rx_ShortFrame;
    logic       Rx_FrameLost;
    hdlc_state_t state;

    modport master (
        output Rx_NewByte, Rx_Data, Rx_ValidFrame, Rx_EoF, Rx_AbortSignal, Rx_RdBuff, Rx_Drop,
        input  Rx_WrBuff, Rx_Ready, Rx_FrameSize, Rx_DataBuff, Rx_Overflow, Rx_ShortFrame,
        input  Rx_FrameLost, state
    );

    modport slave (
        input  Rx_NewByte, Rx_Data, Rx_ValidFrame, Rx_EoF, Rx_AbortSignal, Rx_RdBuff, Rx_Drop,
        output Rx_WrBuff, Rx_Ready, Rx_FrameSize, Rx_DataBuff, Rx_Overflow, Rx_ShortFrame,
        output Rx_FrameLost, state
    );
endinterface

// File: rtl/hdlc_rx_ram.sv
// Frame storage: synchronous write port and an enabled, registered read port.
module hdlc_rx_ram #(
    parameter int DEPTH = hdlc_pkg::BUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data holds between strobes so the host sees a stable last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/hdlc_rx_buffer.sv
// HDLC receive buffer: collects one frame of de-stuffed bytes and hands it to the host.
module hdlc_rx_buffer #(
    parameter int BUF_DEPTH = hdlc_pkg::BUF_DEPTH,
    parameter int FCS_BYTES = hdlc_pkg::FCS_BYTES
) (
    input logic             Clk,
    input logic             Rst,
    hdlc_rx_buffer_if.slave bus
);
    import hdlc_pkg::hdlc_state_t;
    import hdlc_pkg::IDLE;
    import hdlc_pkg::RECV;
    import hdlc_pkg::READY;

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] FCS_C   = CW'(FCS_BYTES);

    hdlc_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]    frame_size_q, frame_size_d;
    logic          overflow_q, overflow_d;
    logic          short_q, short_d;
    logic          lost_q, lost_d;
    logic          we, re;
    logic [AW-1:0] wr_addr;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        frame_size_d = frame_size_q;
        overflow_d   = overflow_q;
        short_d      = 1'b0;
        lost_d       = lost_q;
        we           = 1'b0;
        re           = 1'b0;
        wr_addr      = count_q[AW-1:0];
        case (state_q)
            IDLE: begin
                if (bus.Rx_NewByte && bus.Rx_ValidFrame) begin
                    we         = 1'b1;
                    wr_addr    = '0;
                    count_d    = CW'(1);
                    overflow_d = 1'b0;
                    state_d    = RECV;
                end
            end
            RECV: begin
                // Abort outranks a coincident end-of-frame.
                if (bus.Rx_AbortSignal) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (bus.Rx_EoF) begin
                    if (count_q > FCS_C) begin
                        frame_size_d = 8'(count_q - FCS_C);
                        rd_ptr_d     = '0;
                        state_d      = READY;
                    end else begin
                        short_d = 1'b1;
                        count_d = '0;
                        state_d = IDLE;
                    end
                end else if (bus.Rx_NewByte) begin
                    if (count_q < DEPTH_C) begin
                        we      = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.Rx_Drop) begin
                    state_d = IDLE;
                end else if (bus.Rx_RdBuff) begin
                    re       = 1'b1;
                    rd_ptr_d = rd_ptr_q + 8'd1;
                    if (rd_ptr_q + 8'd1 == frame_size_q) begin
                        state_d = IDLE;
                    end
                end
                if (bus.Rx_NewByte && bus.Rx_ValidFrame) begin
                    lost_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            frame_size_q <= '0;
            overflow_q   <= 1'b0;
            short_q      <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_size_q <= frame_size_d;
            overflow_q   <= overflow_d;
            short_q      <= short_d;
            lost_q       <= lost_d;
        end
    end

    hdlc_rx_ram #(.DEPTH(BUF_DEPTH)) u_ram (
        .clk     (Clk),
        .rst     (Rst),
        .we      (we & ~Rst),
        .wr_addr (wr_addr),
        .wr_data (bus.Rx_Data),
        .re      (re & ~Rst),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (bus.Rx_DataBuff)
    );

    assign bus.Rx_WrBuff     = we & ~Rst;
    assign bus.Rx_Ready      = (state_q == READY);
    assign bus.Rx_FrameSize  = frame_size_q;
    assign bus.Rx_Overflow   = overflow_q;
    assign bus.Rx_ShortFrame = short_q;
    assign bus.Rx_FrameLost  = lost_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_hdlc_rx_buffer.sv
// Self-checking bench for hdlc_rx_buffer: random frames against a queue-based frame model.
module tb_hdlc_rx_buffer;
    import hdlc_pkg::*;

    logic Clk;
    logic Rst;
    int   errors = 0;
    int   checks = 0;
    int   wr_cnt = 0;
    int   short_cnt = 0;
    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];

    hdlc_rx_buffer_if bus ();

    hdlc_rx_buffer #(.BUF_DEPTH(BUF_DEPTH), .FCS_BYTES(FCS_BYTES)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "time limit");
    end

    always @(negedge Clk) begin
        if (bus.Rx_WrBuff === 1'b1) wr_cnt++;
        if (bus.Rx_ShortFrame === 1'b1) short_cnt++;
    end

    // ---------------- reference model ----------------
    // Stored bytes are the first min(n, depth); the payload drops the trailing FCS.
    function automatic int model_size(input int n);
        int stored;
        stored = (n > BUF_DEPTH) ? BUF_DEPTH : n;
        return stored - FCS_BYTES;
    endfunction

    task automatic build_expected();
        int sz;
        exp_q.delete();
        sz = model_size(sent_q.size());
        for (int i = 0; i < sz; i++) exp_q.push_back(sent_q[i]);
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Rx_NewByte = 1'b0;
        bus.Rx_Data = 8'h00;
        bus.Rx_ValidFrame = 1'b0;
        bus.Rx_EoF = 1'b0;
        bus.Rx_AbortSignal = 1'b0;
        bus.Rx_RdBuff = 1'b0;
        bus.Rx_Drop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.Rx_ValidFrame = 1'b1;
        repeat ($urandom_range(0, 2)) tick();
        bus.Rx_NewByte = 1'b1;
        bus.Rx_Data = b;
        tick();
        bus.Rx_NewByte = 1'b0;
        bus.Rx_Data = 8'($urandom);
    endtask

    task automatic send_random(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            sent_q.push_back(b);
            send_byte(b);
        end
    endtask

    task automatic end_frame();
        bus.Rx_EoF = 1'b1;
        tick();
        bus.Rx_EoF = 1'b0;
        bus.Rx_ValidFrame = 1'b0;
    endtask

    task automatic abort_frame();
        bus.Rx_AbortSignal = 1'b1;
        tick();
        bus.Rx_AbortSignal = 1'b0;
        bus.Rx_ValidFrame = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] d, output logic rdy);
        repeat ($urandom_range(0, 1)) tick();
        bus.Rx_RdBuff = 1'b1;
        tick();
        bus.Rx_RdBuff = 1'b0;
        d = bus.Rx_DataBuff;
        rdy = bus.Rx_Ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset(input string tag);
        bus.Rx_NewByte = 1'b1;
        bus.Rx_ValidFrame = 1'b1;
        Rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.Rx_WrBuff !== 1'b0) begin
            errors++; $display("FAIL %s_wrbuff: got %b expected 0", tag, bus.Rx_WrBuff);
        end
        checks++;
        if ({bus.Rx_Ready, bus.Rx_Overflow, bus.Rx_ShortFrame, bus.Rx_FrameLost} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_flags: got rdy/ovf/short/lost=%b%b%b%b expected 0000", tag,
                     bus.Rx_Ready, bus.Rx_Overflow, bus.Rx_ShortFrame, bus.Rx_FrameLost);
        end
        checks++;
        if ({bus.Rx_FrameSize, bus.Rx_DataBuff} !== 16'h0000) begin
            errors++;
            $display("FAIL %s_data: got size=%0d data=%02h expected 0/00", tag,
                     bus.Rx_FrameSize, bus.Rx_DataBuff);
        end
        checks++;
        if (bus.state !== IDLE) begin
            errors++; $display("FAIL %s_state: got %0d expected IDLE", tag, bus.state);
        end
        idle_inputs();
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic rdy;
        sent_q.delete();
        wr_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            sent_q.push_back(8'(i));
            send_byte(8'(i));
        end
        end_frame();
        build_expected();
        checks++;
        if (bus.Rx_Ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready: got %b expected 1", bus.Rx_Ready);
        end
        checks++;
        if (bus.Rx_FrameSize !== 8'd8) begin
            errors++; $display("FAIL basic_size: got %0d expected 8", bus.Rx_FrameSize);
        end
        checks++;
        if (wr_cnt != 10) begin
            errors++; $display("FAIL basic_wrcnt: got %0d expected 10", wr_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            read_byte(d, rdy);
            checks++;
            if (d !== exp_q[i] || rdy !== (i < 7)) begin
                errors++;
                $display("FAIL basic_read%0d: got data=%02h rdy=%b expected %02h rdy=%b",
                         i, d, rdy, exp_q[i], (i < 7));
            end
        end
        read_byte(d, rdy);
        checks++;
        if (d !== 8'h08 || rdy !== 1'b0 || bus.state !== IDLE) begin
            errors++;
            $display("FAIL basic_extra_read: got data=%02h rdy=%b state=%0d expected 08/0/IDLE",
                     d, rdy, bus.state);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic rdy;
        int n;
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(3, 40);
            sent_q.delete();
            wr_cnt = 0;
            send_random(n);
            bus.Rx_RdBuff = 1'b1;
            bus.Rx_Drop = 1'b1;
            tick();
            bus.Rx_RdBuff = 1'b0;
            bus.Rx_Drop = 1'b0;
            end_frame();
            build_expected();
            checks++;
            if (bus.Rx_Ready !== 1'b1 || bus.Rx_FrameSize !== 8'(model_size(n)) || wr_cnt != n) begin
                errors++;
                $display("FAIL rand%0d_frame: got rdy=%b size=%0d wr=%0d expected 1/%0d/%0d",
                         f, bus.Rx_Ready, bus.Rx_FrameSize, wr_cnt, model_size(n), n);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                read_byte(d, rdy);
                checks++;
                if (d !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_data%0d: got %02h expected %02h", f, i, d, exp_q[i]);
                end
            end
            checks++;
            if (bus.Rx_Ready !== 1'b0) begin
                errors++; $display("FAIL rand%0d_done: got rdy=%b expected 0", f, bus.Rx_Ready);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic rdy;
        sent_q.delete();
        wr_cnt = 0;
        send_random(BUF_DEPTH);
        checks++;
        if (bus.Rx_Overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_early: got %b expected 0", bus.Rx_Overflow);
        end
        send_random(1);
        checks++;
        if (bus.Rx_Overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got %b expected 1", bus.Rx_Overflow);
        end
        send_random(1);
        end_frame();
        build_expected();
        checks++;
        if (wr_cnt != BUF_DEPTH || bus.Rx_FrameSize !== 8'(model_size(BUF_DEPTH + 2))) begin
            errors++;
            $display("FAIL ovf_size: got wr=%0d size=%0d expected %0d/%0d",
                     wr_cnt, bus.Rx_FrameSize, BUF_DEPTH, model_size(BUF_DEPTH + 2));
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            read_byte(d, rdy);
            checks++;
            if (d !== exp_q[i]) begin
                errors++; $display("FAIL ovf_data%0d: got %02h expected %02h", i, d, exp_q[i]);
            end
        end
        checks++;
        if (bus.Rx_Overflow !== 1'b1 || bus.Rx_Ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b rdy=%b expected 1/0", bus.Rx_Overflow, bus.Rx_Ready);
        end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic rdy;
        sent_q.delete();
        send_random(1);
        checks++;
        if (bus.Rx_Overflow !== 1'b0) begin
            errors++; $display("FAIL abort_ovf_clear: got %b expected 0", bus.Rx_Overflow);
        end
        send_random(4);
        abort_frame();
        tick();
        checks++;
        if (bus.Rx_Ready !== 1'b0 || bus.state !== IDLE) begin
            errors++;
            $display("FAIL abort_idle: got rdy=%b state=%0d expected 0/IDLE", bus.Rx_Ready, bus.state);
        end
        sent_q.delete();
        send_random(4);
        end_frame();
        build_expected();
        checks++;
        if (bus.Rx_Ready !== 1'b1 || bus.Rx_FrameSize !== 8'd2) begin
            errors++;
            $display("FAIL abort_next: got rdy=%b size=%0d expected 1/2", bus.Rx_Ready, bus.Rx_FrameSize);
        end
        for (int i = 0; i < 2; i++) begin
            read_byte(d, rdy);
            checks++;
            if (d !== exp_q[i]) begin
                errors++; $display("FAIL abort_data%0d: got %02h expected %02h", i, d, exp_q[i]);
            end
        end
        sent_q.delete();
        send_random(3);
        bus.Rx_EoF = 1'b1;
        abort_frame();
        bus.Rx_EoF = 1'b0;
        checks++;
        if (bus.Rx_Ready !== 1'b0 || bus.Rx_ShortFrame !== 1'b0 || bus.state !== IDLE) begin
            errors++;
            $display("FAIL abort_with_eof: got rdy=%b short=%b state=%0d expected 0/0/IDLE",
                     bus.Rx_Ready, bus.Rx_ShortFrame, bus.state);
        end
    endtask

    task automatic test_short();
        sent_q.delete();
        send_random(FCS_BYTES);
        short_cnt = 0;
        end_frame();
        checks++;
        if (bus.Rx_ShortFrame !== 1'b1 || bus.Rx_Ready !== 1'b0 || bus.state !== IDLE) begin
            errors++;
            $display("FAIL short_pulse: got short=%b rdy=%b state=%0d expected 1/0/IDLE",
                     bus.Rx_ShortFrame, bus.Rx_Ready, bus.state);
        end
        repeat (3) tick();
        checks++;
        if (short_cnt != 1) begin
            errors++; $display("FAIL short_width: got %0d cycles expected 1", short_cnt);
        end
    endtask

    task automatic test_drop();
        logic [7:0] d0;
        logic rdy;
        sent_q.delete();
        send_random($urandom_range(6, 12));
        end_frame();
        build_expected();
        read_byte(d0, rdy);
        checks++;
        if (d0 !== exp_q[0]) begin
            errors++; $display("FAIL drop_first: got %02h expected %02h", d0, exp_q[0]);
        end
        bus.Rx_Drop = 1'b1;
        bus.Rx_RdBuff = 1'b1;
        tick();
        bus.Rx_Drop = 1'b0;
        bus.Rx_RdBuff = 1'b0;
        checks++;
        if (bus.Rx_Ready !== 1'b0 || bus.Rx_DataBuff !== exp_q[0] || bus.state !== IDLE) begin
            errors++;
            $display("FAIL drop_win: got rdy=%b data=%02h state=%0d expected 0/%02h/IDLE",
                     bus.Rx_Ready, bus.Rx_DataBuff, bus.state, exp_q[0]);
        end
        bus.Rx_RdBuff = 1'b1;
        tick();
        bus.Rx_RdBuff = 1'b0;
        checks++;
        if (bus.Rx_DataBuff !== exp_q[0]) begin
            errors++; $display("FAIL drop_idle_read: got %02h expected %02h", bus.Rx_DataBuff, exp_q[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        logic rdy;
        sent_q.delete();
        send_random(6);
        end_frame();
        read_byte(d, rdy);
        test_reset("rst_mid");
        sent_q.delete();
        send_random(5);
        end_frame();
        build_expected();
        checks++;
        if (bus.Rx_FrameSize !== 8'd3) begin
            errors++; $display("FAIL rst_mid_size: got %0d expected 3", bus.Rx_FrameSize);
        end
        for (int i = 0; i < 3; i++) begin
            read_byte(d, rdy);
            checks++;
            if (d !== exp_q[i]) begin
                errors++; $display("FAIL rst_mid_data%0d: got %02h expected %02h", i, d, exp_q[i]);
            end
        end
    endtask

    task automatic test_frame_lost();
        logic [7:0] d;
        logic rdy;
        sent_q.delete();
        send_random(8);
        end_frame();
        build_expected();
        checks++;
        if (bus.Rx_FrameLost !== 1'b0) begin
            errors++; $display("FAIL lost_early: got %b expected 0", bus.Rx_FrameLost);
        end
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        end_frame();
        checks++;
        if (bus.Rx_FrameLost !== 1'b1 || wr_cnt != 0 || bus.Rx_Ready !== 1'b1 ||
            bus.Rx_FrameSize !== 8'(exp_q.size())) begin
            errors++;
            $display("FAIL lost_set: got lost=%b wr=%0d rdy=%b size=%0d expected 1/0/1/%0d",
                     bus.Rx_FrameLost, wr_cnt, bus.Rx_Ready, bus.Rx_FrameSize, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            read_byte(d, rdy);
            checks++;
            if (d !== exp_q[i]) begin
                errors++; $display("FAIL lost_data%0d: got %02h expected %02h", i, d, exp_q[i]);
            end
        end
        checks++;
        if (bus.Rx_FrameLost !== 1'b1) begin
            errors++; $display("FAIL lost_sticky: got %b expected 1", bus.Rx_FrameLost);
        end
    endtask

    initial begin
        Rst = 1'b1;
        idle_inputs();
        test_reset("reset");
        test_basic();
        test_random_frames();
        test_overflow();
        test_abort();
        test_short();
        test_drop();
        test_reset_mid_read();
        test_frame_lost();
        test_reset("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
